// File: rtl/noc_pkg.sv
// Shared NoC definitions: direction codes, FSM states, header layout and XY routing.
package noc_pkg;

  typedef enum logic [2:0] {
    DIR_N    = 3'b000,
    DIR_S    = 3'b001,
    DIR_W    = 3'b010,
    DIR_E    = 3'b011,
    DIR_L    = 3'b100,
    DIR_NONE = 3'b111
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } req_state_t;

  // Widest coordinate the routing function handles.
  localparam int unsigned ROUTE_W = 8;

  // Header sits in the top bits of the flit: {dest_x, dest_y, payload}.
  function automatic int unsigned dest_x_lsb(input int unsigned flit_w, input int unsigned coord_w);
    return flit_w - coord_w;
  endfunction

  function automatic int unsigned dest_y_lsb(input int unsigned flit_w, input int unsigned coord_w);
    return flit_w - 2 * coord_w;
  endfunction

  // Dimension-ordered routing: resolve X first, then Y, else local.
  function automatic dir_t xy_route(input logic [ROUTE_W-1:0] dest_x, input logic [ROUTE_W-1:0] dest_y,
                                    input logic [ROUTE_W-1:0] my_x,   input logic [ROUTE_W-1:0] my_y);
    if (dest_x > my_x)      return DIR_E;
    else if (dest_x < my_x) return DIR_W;
    else if (dest_y > my_y) return DIR_N;
    else if (dest_y < my_y) return DIR_S;
    else                    return DIR_L;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous power-of-two FIFO; also exposes the entry behind the head.
module flit_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               head_o,
  output logic [W-1:0]               head2_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign head2_o = mem_q[AW'(rd_ptr_q + AW'(1))];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer, occupancy and storage update.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = AW'(wr_ptr_q + AW'(1));
    end
    if (do_pop) rd_ptr_d = AW'(rd_ptr_q + AW'(1));
    count_d = CW'(count_q + CW'(do_push) - CW'(do_pop));
  end

  // Control state, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; occupancy guards every read that matters.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rr_input_requester.sv
// Input-port requester: buffers flits, requests the XY-routed output, sends on grant.
module rr_input_requester
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W      = 32,
  parameter int unsigned COORD_W     = 2,
  parameter int unsigned MY_X        = 0,
  parameter int unsigned MY_Y        = 0,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned STALL_LIMIT = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] flit_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [2:0]        nexthop_addr_o,
  input  logic              grant_n_i,
  input  logic              grant_s_i,
  input  logic              grant_w_i,
  input  logic              grant_e_i,
  input  logic              grant_l_i,
  output logic [FLIT_W-1:0] flit_o,
  output logic              flit_valid_o,
  output logic              change_order_o,
  output logic              stall_o
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned X_LSB = dest_x_lsb(FLIT_W, COORD_W);
  localparam int unsigned Y_LSB = dest_y_lsb(FLIT_W, COORD_W);

  req_state_t        state_q, state_d;
  dir_t              nexthop_q, nexthop_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              flit_valid_q, flit_valid_d;
  logic              change_order_q, change_order_d;
  logic              stall_q, stall_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic              push, pop;
  logic [FLIT_W-1:0] head, head2, next_flit;
  logic [CW-1:0]     count, cnt_after;
  logic              fifo_full, fifo_empty;
  logic              sel_grant;
  dir_t              head_route, next_route;

  assign ready_o = reset && !fifo_full;
  assign push    = valid_i && ready_o;

  flit_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (flit_i),
    .head_o  (head),
    .head2_o (head2),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Route of the current head and of whatever becomes head after a pop.
  always_comb begin
    next_flit  = (count > CW'(1)) ? head2 : flit_i;
    cnt_after  = CW'(count - CW'(1) + CW'(push));
    head_route = xy_route(ROUTE_W'(head[X_LSB +: COORD_W]), ROUTE_W'(head[Y_LSB +: COORD_W]),
                          ROUTE_W'(MY_X), ROUTE_W'(MY_Y));
    next_route = xy_route(ROUTE_W'(next_flit[X_LSB +: COORD_W]), ROUTE_W'(next_flit[Y_LSB +: COORD_W]),
                          ROUTE_W'(MY_X), ROUTE_W'(MY_Y));
  end

  // Only the grant from the requested output counts.
  always_comb begin
    sel_grant = 1'b0;
    case (nexthop_q)
      DIR_N:   sel_grant = grant_n_i;
      DIR_S:   sel_grant = grant_s_i;
      DIR_W:   sel_grant = grant_w_i;
      DIR_E:   sel_grant = grant_e_i;
      DIR_L:   sel_grant = grant_l_i;
      default: sel_grant = 1'b0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    nexthop_d      = nexthop_q;
    flit_d         = flit_q;
    flit_valid_d   = 1'b0;
    change_order_d = 1'b0;
    wait_cnt_d     = wait_cnt_q;
    stall_d        = (wait_cnt_q >= CNT_W'(STALL_LIMIT));
    pop            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        nexthop_d  = DIR_NONE;
        wait_cnt_d = '0;
        if (!fifo_empty) begin
          nexthop_d = head_route;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sel_grant) begin
          state_d        = ST_SEND;
          flit_d         = head;
          flit_valid_d   = 1'b1;
          change_order_d = 1'b1;
          wait_cnt_d     = '0;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = CNT_W'(wait_cnt_q + CNT_W'(1));
        end
      end
      ST_SEND: begin
        pop = 1'b1;
        if (cnt_after != '0) begin
          nexthop_d = next_route;
          state_d   = ST_REQ;
        end else begin
          nexthop_d = DIR_NONE;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        nexthop_d = DIR_NONE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      nexthop_q      <= DIR_NONE;
      flit_q         <= '0;
      flit_valid_q   <= 1'b0;
      change_order_q <= 1'b0;
      stall_q        <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      nexthop_q      <= nexthop_d;
      flit_q         <= flit_d;
      flit_valid_q   <= flit_valid_d;
      change_order_q <= change_order_d;
      stall_q        <= stall_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign nexthop_addr_o = nexthop_q;
  assign flit_o         = flit_q;
  assign flit_valid_o   = flit_valid_q;
  assign change_order_o = change_order_q;
  assign stall_o        = stall_q;

endmodule

// File: tb/tb_rr_input_requester.sv
// Directed bench for rr_input_requester at router position (1,1).
module tb_rr_input_requester;

  localparam int unsigned FLIT_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLIT_W-1:0] flit_i;
  logic              valid_i;
  logic              ready_o;
  logic [2:0]        nexthop_addr_o;
  logic              grant_n_i, grant_s_i, grant_w_i, grant_e_i, grant_l_i;
  logic [FLIT_W-1:0] flit_o;
  logic              flit_valid_o;
  logic              change_order_o;
  logic              stall_o;

  int pass_cnt = 0;
  int total    = 0;

  rr_input_requester #(
    .FLIT_W(FLIT_W), .COORD_W(2), .MY_X(1), .MY_Y(1),
    .DEPTH(4), .CNT_W(4), .STALL_LIMIT(12)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flit_i         (flit_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .nexthop_addr_o (nexthop_addr_o),
    .grant_n_i      (grant_n_i),
    .grant_s_i      (grant_s_i),
    .grant_w_i      (grant_w_i),
    .grant_e_i      (grant_e_i),
    .grant_l_i      (grant_l_i),
    .flit_o         (flit_o),
    .flit_valid_o   (flit_valid_o),
    .change_order_o (change_order_o),
    .stall_o        (stall_o)
  );

  always #5 clk = ~clk;

  // Advance into the next cycle; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0] dx, input logic [1:0] dy,
                                                 input logic [27:0] payload);
    return {dx, dy, payload};
  endfunction

  task automatic set_grants(input logic [2:0] dir, input logic val);
    grant_n_i = (dir == 3'b000) ? val : 1'b0;
    grant_s_i = (dir == 3'b001) ? val : 1'b0;
    grant_w_i = (dir == 3'b010) ? val : 1'b0;
    grant_e_i = (dir == 3'b011) ? val : 1'b0;
    grant_l_i = (dir == 3'b100) ? val : 1'b0;
  endtask

  // Present one flit for a single cycle; returns in the cycle after acceptance.
  task automatic send_flit(input logic [FLIT_W-1:0] f);
    valid_i = 1'b1;
    flit_i  = f;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_i = 1'b0; flit_i = '0; set_grants(3'b111, 1'b0);
    tick(); tick();
    total++; if (nexthop_addr_o !== 3'b111) $display("FAIL rst_nexthop got %b exp 111", nexthop_addr_o); else pass_cnt++;
    total++; if (flit_valid_o !== 1'b0 || change_order_o !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL rst_flags got v=%b co=%b st=%b exp 0", flit_valid_o, change_order_o, stall_o); else pass_cnt++;
    total++; if (flit_o !== '0) $display("FAIL rst_flit got %h exp 0", flit_o); else pass_cnt++;
    total++; if (ready_o !== 1'b0) $display("FAIL rst_ready got %b exp 0", ready_o); else pass_cnt++;
    reset = 1'b1;
    #1;
    total++; if (ready_o !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", ready_o); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [FLIT_W-1:0] f;
    f = mk_flit(2'd3, 2'd1, 28'h0A0B0C1);
    send_flit(f);
    total++; if (nexthop_addr_o !== 3'b111) $display("FAIL basic_t1 got %b exp 111", nexthop_addr_o); else pass_cnt++;
    tick();
    total++; if (nexthop_addr_o !== 3'b011) $display("FAIL basic_t2_req got %b exp 011", nexthop_addr_o); else pass_cnt++;
    grant_e_i = 1'b1;
    tick();
    grant_e_i = 1'b0;
    total++; if (flit_valid_o !== 1'b1 || change_order_o !== 1'b1)
      $display("FAIL basic_t3_send got v=%b co=%b exp 1 1", flit_valid_o, change_order_o); else pass_cnt++;
    total++; if (flit_o !== f) $display("FAIL basic_t3_flit got %h exp %h", flit_o, f); else pass_cnt++;
    total++; if (nexthop_addr_o !== 3'b011) $display("FAIL basic_t3_hold got %b exp 011", nexthop_addr_o); else pass_cnt++;
    tick();
    total++; if (nexthop_addr_o !== 3'b111 || flit_valid_o !== 1'b0 || change_order_o !== 1'b0)
      $display("FAIL basic_t4_idle got nh=%b v=%b co=%b exp 111 0 0", nexthop_addr_o, flit_valid_o, change_order_o); else pass_cnt++;
  endtask

  task automatic test_routes();
    logic [1:0] dx [4];
    logic [1:0] dy [4];
    logic [2:0] exp_dir [4];
    logic [FLIT_W-1:0] f;
    dx = '{2'd0, 2'd1, 2'd1, 2'd1};
    dy = '{2'd2, 2'd2, 2'd0, 2'd1};
    exp_dir = '{3'b010, 3'b000, 3'b001, 3'b100};
    for (int i = 0; i < 4; i++) begin
      f = mk_flit(dx[i], dy[i], 28'(32'h100 + i));
      send_flit(f);
      tick();
      total++; if (nexthop_addr_o !== exp_dir[i]) $display("FAIL route_%0d got %b exp %b", i, nexthop_addr_o, exp_dir[i]); else pass_cnt++;
      if (i == 0) begin
        grant_n_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          total++; if (flit_valid_o !== 1'b0 || nexthop_addr_o !== 3'b010)
            $display("FAIL route_wrong_grant_%0d got v=%b nh=%b exp 0 010", k, flit_valid_o, nexthop_addr_o); else pass_cnt++;
        end
        grant_n_i = 1'b0;
      end
      set_grants(exp_dir[i], 1'b1);
      tick();
      set_grants(3'b111, 1'b0);
      total++; if (flit_valid_o !== 1'b1 || flit_o !== f)
        $display("FAIL route_send_%0d got v=%b f=%h exp 1 %h", i, flit_valid_o, flit_o, f); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [FLIT_W-1:0] fl [4];
    for (int i = 0; i < 4; i++) begin
      fl[i] = mk_flit(2'd2, 2'd1, 28'(32'hB00 + i));
      send_flit(fl[i]);
    end
    total++; if (ready_o !== 1'b0) $display("FAIL fill_full_ready got %b exp 0", ready_o); else pass_cnt++;
    grant_e_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (flit_valid_o !== ((k % 2) == 0))
        $display("FAIL b2b_valid_%0d got %b exp %b", k, flit_valid_o, ((k % 2) == 0)); else pass_cnt++;
      if ((k % 2) == 0) begin
        total++; if (flit_o !== fl[k/2]) $display("FAIL b2b_order_%0d got %h exp %h", k, flit_o, fl[k/2]); else pass_cnt++;
      end
      if (k == 0) begin
        total++; if (ready_o !== 1'b0) $display("FAIL b2b_ready_send got %b exp 0", ready_o); else pass_cnt++;
      end
      if (k == 1) begin
        total++; if (ready_o !== 1'b1) $display("FAIL b2b_ready_after_pop got %b exp 1", ready_o); else pass_cnt++;
      end
    end
    total++; if (nexthop_addr_o !== 3'b111) $display("FAIL b2b_idle got %b exp 111", nexthop_addr_o); else pass_cnt++;
    grant_e_i = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    send_flit(mk_flit(2'd1, 2'd0, 28'h5555));
    tick();
    for (int k = 0; k < 20; k++) begin
      total++; if (stall_o !== (k >= 13)) $display("FAIL stall_%0d got %b exp %b", k, stall_o, (k >= 13)); else pass_cnt++;
      tick();
    end
    grant_s_i = 1'b1;
    tick();
    grant_s_i = 1'b0;
    total++; if (flit_valid_o !== 1'b1 || stall_o !== 1'b1)
      $display("FAIL stall_send got v=%b st=%b exp 1 1", flit_valid_o, stall_o); else pass_cnt++;
    tick();
    total++; if (stall_o !== 1'b0) $display("FAIL stall_clear got %b exp 0", stall_o); else pass_cnt++;
  endtask

  task automatic test_push_in_send();
    logic [FLIT_W-1:0] fa, fb;
    fa = mk_flit(2'd3, 2'd1, 28'hAAA);
    fb = mk_flit(2'd0, 2'd1, 28'hBBB);
    send_flit(fa);
    tick();
    grant_e_i = 1'b1;
    tick();
    grant_e_i = 1'b0;
    valid_i = 1'b1; flit_i = fb;
    #1;
    total++; if (flit_valid_o !== 1'b1 || ready_o !== 1'b1)
      $display("FAIL pis_send got v=%b rdy=%b exp 1 1", flit_valid_o, ready_o); else pass_cnt++;
    tick();
    valid_i = 1'b0;
    total++; if (nexthop_addr_o !== 3'b010) $display("FAIL pis_direct_req got %b exp 010", nexthop_addr_o); else pass_cnt++;
    tick();
    total++; if (nexthop_addr_o !== 3'b010) $display("FAIL pis_hold_req got %b exp 010", nexthop_addr_o); else pass_cnt++;
    grant_w_i = 1'b1;
    tick();
    grant_w_i = 1'b0;
    total++; if (flit_valid_o !== 1'b1 || flit_o !== fb)
      $display("FAIL pis_second got v=%b f=%h exp 1 %h", flit_valid_o, flit_o, fb); else pass_cnt++;
    tick();
    total++; if (nexthop_addr_o !== 3'b111) $display("FAIL pis_idle got %b exp 111", nexthop_addr_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send_flit(mk_flit(2'd2, 2'd1, 28'(32'hC00 + i)));
    grant_e_i = 1'b1;
    tick();
    grant_e_i = 1'b0;
    total++; if (flit_valid_o !== 1'b1) $display("FAIL rmid_in_send got %b exp 1", flit_valid_o); else pass_cnt++;
    reset = 1'b0;
    #1;
    total++; if (ready_o !== 1'b0) $display("FAIL rmid_ready_low got %b exp 0", ready_o); else pass_cnt++;
    tick();
    total++; if (nexthop_addr_o !== 3'b111 || flit_valid_o !== 1'b0 || change_order_o !== 1'b0 || stall_o !== 1'b0 || flit_o !== '0)
      $display("FAIL rmid_outputs got nh=%b v=%b co=%b st=%b f=%h exp 111 0 0 0 0",
               nexthop_addr_o, flit_valid_o, change_order_o, stall_o, flit_o); else pass_cnt++;
    reset = 1'b1;
    #1;
    total++; if (ready_o !== 1'b1) $display("FAIL rmid_ready_release got %b exp 1", ready_o); else pass_cnt++;
    grant_e_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (flit_valid_o !== 1'b0 || change_order_o !== 1'b0 || nexthop_addr_o !== 3'b111)
        $display("FAIL rmid_no_stale_%0d got v=%b co=%b nh=%b exp 0 0 111", k, flit_valid_o, change_order_o, nexthop_addr_o); else pass_cnt++;
    end
    grant_e_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_routes();
    test_back_to_back();
    test_stall();
    test_push_in_send();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/rr_input_requester.md
Name: rr_input_requester

Overview:
- Input-port side of the round-robin arbitration handshake; one instance per router input (N/S/W/E/L).
- Buffers incoming single-flit packets and XY-routes the head flit.
- Drives the 3-bit next-hop address into every output-port rr processor, then waits for the grant bit from the targeted output.
- On grant, presents the flit to the crossbar switch and pulses change_order so the arbiter's rr registers rotate.

Parameters:
- FLIT_W, 32, flit width; header = top 2*COORD_W bits {dest_x, dest_y}
- COORD_W, 2, width of each mesh coordinate
- MY_X, 0, this router's x coordinate
- MY_Y, 0, this router's y coordinate
- DEPTH, 4, FIFO entries (power of 2, >=2)
- CNT_W, 4, wait counter width
- STALL_LIMIT, 12, REQ-cycle count at which stall_o asserts (< 2^CNT_W)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- flit_i  in  FLIT_W  incoming flit from upstream
- valid_i  in  1  flit_i valid
- ready_o  out  1  FIFO can accept; transfer when valid_i && ready_o
- nexthop_addr_o  out  3  requested output direction, fans out to all rr processors
- grant_n_i / grant_s_i / grant_w_i / grant_e_i / grant_l_i  in  1 each  this input's priority bit from the N/S/W/E/L output arbiter
- flit_o  out  FLIT_W  flit to crossbar
- flit_valid_o  out  1  flit_o valid (one cycle per flit)
- change_order_o  out  1  one-cycle pulse to rr register change_order input
- stall_o  out  1  request outstanding >= STALL_LIMIT cycles

Behaviour:
- Direction codes: N=3'b000, S=3'b001, W=3'b010, E=3'b011, L=3'b100, NONE=3'b111.
- Reset (reset==0 at posedge) clears FIFO pointers and count and forces state IDLE.
- Reset values: nexthop_addr_o=NONE, flit_o=0, flit_valid_o=0, change_order_o=0, stall_o=0, wait_cnt=0.
- ready_o = reset && (count != DEPTH), combinational; it is 0 while reset is held low.
- Push when valid_i && ready_o. No push when full, even if a pop happens in the same cycle.
- Routing of the FIFO head, X first:
  - dest_x > MY_X -> E
  - dest_x < MY_X -> W
  - otherwise dest_y > MY_Y -> N
  - otherwise dest_y < MY_Y -> S
  - otherwise L
  - Comparisons are unsigned.
- FSM, registered outputs:
  - IDLE: nexthop_addr_o=NONE. If count != 0, load the routed direction into nexthop_addr_o and go to REQ.
  - REQ: hold nexthop_addr_o. The selected grant is the grant_*_i matching nexthop_addr_o; all others are ignored. If it is 1, go to SEND. Otherwise increment wait_cnt, saturating at 2^CNT_W-1.
  - SEND: flit_o=head, flit_valid_o=1, change_order_o=1, nexthop_addr_o unchanged; pop at the end of the cycle. If count-after-pop != 0, load the next head's route and go to REQ; else set nexthop_addr_o=NONE and go to IDLE.
- Push during SEND counts toward count-after-pop.
- wait_cnt clears on exiting REQ. stall_o = (wait_cnt >= STALL_LIMIT), registered.
- Latency: flit accepted in cycle t -> request visible at t+2 -> grant sampled at t+2 -> flit_valid_o at t+3. Back-to-back flits get one grant opportunity every 2 cycles.
- A grant arriving while in IDLE or SEND is ignored.
- A grant glitch on a non-selected output is ignored.
- Reset mid-REQ/SEND: all buffered flits are dropped, with no change_order pulse.

Decomposition:
- noc_pkg holds the dir_t codes (including DIR_NONE), the header field offsets, and the xy_route function (so the routing rule has one definition).
- Natural sub-module: flit_fifo, a parameterised synchronous FIFO exposing push, pop, head, count, full and empty.

Test Plan:
- Reset, then MY_X=1, MY_Y=1, one flit with dest (3,1) at t -> nexthop_addr_o=3'b011 at t+2; grant_e_i=1 at t+2 -> flit_valid_o=1, change_order_o=1 at t+3; nexthop_addr_o=3'b111 at t+4.
- Route coverage from MY=(1,1): dest (0,2)->W, (1,2)->N, (1,0)->S, (1,1)->L. Only the matching grant advances; grant_n_i held high for a W request -> no SEND.
- Fill 4 flits without grants -> ready_o=0 after the 4th. Hold the grant high -> flits exit at a 2-cycle spacing, in order; ready_o reasserts in the cycle after the first pop.
- Withhold the grant 12 cycles in REQ -> stall_o=1 from the cycle after wait_cnt reaches 12. Grant -> stall_o=0 one cycle after SEND.
- Push during SEND with count=1 -> FSM goes directly to REQ with the new route, no IDLE cycle.
- Assert reset=0 during SEND with 3 flits buffered -> next cycle all outputs at reset values, ready_o=0 during reset and 1 after release, no stale flit emitted.
